// File: rtl/ppu_vram_ctrl_if.sv
// ---------------------------------------------------------------------------
// ppu_vram_ctrl_if
// PPU memory-port bundle between ppu_top and ppu_vram_ctrl.
//   ppu_addr   : 14-bit PPU address
//   ppu_wdata  : write data
//   ppu_rd_req : single-cycle read request
//   ppu_wr_req : single-cycle write request
//   ppu_rdata  : read data, held until the next read completes
//   ppu_ack    : one-cycle completion pulse
//   busy       : controller has an access in flight
// master = PPU side, slave = memory controller side.
// ---------------------------------------------------------------------------
interface ppu_vram_ctrl_if;
   logic [13:0] ppu_addr;
   logic [7:0]  ppu_wdata;
   logic        ppu_rd_req;
   logic        ppu_wr_req;
   logic [7:0]  ppu_rdata;
   logic        ppu_ack;
   logic        busy;

   modport master (
      output ppu_addr, ppu_wdata, ppu_rd_req, ppu_wr_req,
      input  ppu_rdata, ppu_ack, busy
   );

   modport slave (
      input  ppu_addr, ppu_wdata, ppu_rd_req, ppu_wr_req,
      output ppu_rdata, ppu_ack, busy
   );
endinterface

// File: rtl/ppu_vram_ctrl.sv
// ---------------------------------------------------------------------------
// ppu_vram_ctrl
// PPU-side memory controller. Decodes the 14-bit PPU address space into
// external CHR space (req/ack handshake), internal nametable RAM (CIRAM,
// horizontal/vertical mirroring) and the 32-entry palette RAM.
//
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   io_ppu           : PPU memory bus (slave modport)
//   i_mirror_v       : 1 = vertical mirroring, 0 = horizontal (latched on accept)
//   o_chr_addr/wdata : CHR address / write data
//   o_chr_rd/wr      : CHR strobes, held until i_chr_ack or timeout
//   i_chr_rdata      : CHR read data, valid with i_chr_ack
//   i_chr_ack        : CHR completion
//   o_overrun        : sticky, a request arrived while busy
//   o_chr_timeout    : sticky, a CHR access timed out
// ---------------------------------------------------------------------------
module ppu_vram_ctrl #(
   parameter int CHR_TIMEOUT = 15,
   parameter int NT_DEPTH    = 2048
) (
   input  logic              i_clk,
   input  logic              i_rst,
   ppu_vram_ctrl_if.slave    io_ppu,
   input  logic              i_mirror_v,
   output logic [12:0]       o_chr_addr,
   output logic [7:0]        o_chr_wdata,
   output logic              o_chr_rd,
   output logic              o_chr_wr,
   input  logic [7:0]        i_chr_rdata,
   input  logic              i_chr_ack,
   output logic              o_overrun,
   output logic              o_chr_timeout
);

   localparam logic [3:0] TMO = 4'(CHR_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PAL,
      S_NT_RD,
      S_CHR,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [11:0] r_addr;        // bit 12 is never needed after accept
   logic        r_is_nt;       // latched access targets the nametable
   logic [7:0]  r_wdata;
   logic        r_wr;
   logic        r_mirror_v;
   logic [3:0]  r_cnt;
   logic [7:0]  r_rdata;
   logic [7:0]  r_rbuf;        // CHR read result waiting for DONE
   logic        r_ack;
   logic [12:0] r_chr_addr;
   logic [7:0]  r_chr_wdata;
   logic        r_chr_rd;
   logic        r_chr_wr;
   logic        r_overrun;
   logic        r_chr_timeout;

   logic [5:0]  r_pal [32];
   logic [7:0]  r_nt_ram [NT_DEPTH];
   logic [7:0]  r_nt_q;

   logic        w_req;
   logic        w_acc_chr;
   logic        w_acc_pal;
   logic [4:0]  w_pal_idx;
   logic [10:0] w_nt_addr;
   logic        w_nt_we;

   assign w_req     = io_ppu.ppu_rd_req | io_ppu.ppu_wr_req;
   assign w_acc_chr = ~io_ppu.ppu_addr[13];
   assign w_acc_pal = (io_ppu.ppu_addr[13:8] == 6'h3F);

   // Entries 10/14/18/1C share storage with 00/04/08/0C.
   assign w_pal_idx = {r_addr[4] & (|r_addr[1:0]), r_addr[3:0]};

   // Mirroring selects which address bit picks the physical 1 KB table.
   assign w_nt_addr = r_mirror_v ? {r_addr[10], r_addr[9:0]}
                                 : {r_addr[11], r_addr[9:0]};

   // Nametable writes land in DONE, one cycle after accept.
   assign w_nt_we = (r_state == S_DONE) && r_wr && r_is_nt;

   // CIRAM: plain synchronous RAM, contents survive reset.
   always_ff @(posedge i_clk) begin
      if (w_nt_we) begin
         r_nt_ram[w_nt_addr] <= r_wdata;
      end
      r_nt_q <= r_nt_ram[w_nt_addr];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_addr        <= '0;
         r_is_nt       <= 1'b0;
         r_wdata       <= '0;
         r_wr          <= 1'b0;
         r_mirror_v    <= 1'b0;
         r_cnt         <= '0;
         r_rdata       <= '0;
         r_rbuf        <= '0;
         r_ack         <= 1'b0;
         r_chr_addr    <= '0;
         r_chr_wdata   <= '0;
         r_chr_rd      <= 1'b0;
         r_chr_wr      <= 1'b0;
         r_overrun     <= 1'b0;
         r_chr_timeout <= 1'b0;
         for (int i = 0; i < 32; i++) begin
            r_pal[i] <= '0;
         end
      end else begin
         r_ack <= 1'b0;

         if ((r_state != S_IDLE) && w_req) begin
            r_overrun <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_addr     <= io_ppu.ppu_addr[11:0];
                  r_wdata    <= io_ppu.ppu_wdata;
                  // A simultaneous read is dropped in favour of the write.
                  r_wr       <= io_ppu.ppu_wr_req;
                  r_mirror_v <= i_mirror_v;
                  r_is_nt    <= ~w_acc_chr & ~w_acc_pal;
                  if (w_acc_chr) begin
                     r_state     <= S_CHR;
                     r_chr_addr  <= io_ppu.ppu_addr[12:0];
                     r_chr_wdata <= io_ppu.ppu_wdata;
                     r_chr_rd    <= ~io_ppu.ppu_wr_req;
                     r_chr_wr    <= io_ppu.ppu_wr_req;
                     r_cnt       <= '0;
                  end else if (w_acc_pal) begin
                     r_state <= S_PAL;
                  end else if (io_ppu.ppu_wr_req) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_NT_RD;
                  end
               end
            end

            S_PAL: begin
               if (r_wr) begin
                  r_pal[w_pal_idx] <= r_wdata[5:0];
               end else begin
                  r_rdata <= {2'b00, r_pal[w_pal_idx]};
               end
               r_ack   <= 1'b1;
               r_state <= S_IDLE;
            end

            S_NT_RD: begin
               // r_nt_q is loaded on this edge and consumed in DONE.
               r_state <= S_DONE;
            end

            S_CHR: begin
               // An ack on the timeout cycle wins over the timeout.
               if (i_chr_ack) begin
                  r_rbuf   <= i_chr_rdata;
                  r_chr_rd <= 1'b0;
                  r_chr_wr <= 1'b0;
                  r_state  <= S_DONE;
               end else if (r_cnt == TMO) begin
                  r_chr_timeout <= 1'b1;
                  r_rbuf        <= 8'h00;
                  r_chr_rd      <= 1'b0;
                  r_chr_wr      <= 1'b0;
                  r_state       <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end

            S_DONE: begin
               if (!r_wr) begin
                  r_rdata <= r_is_nt ? r_nt_q : r_rbuf;
               end
               r_ack   <= 1'b1;
               r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_ppu.ppu_rdata = r_rdata;
   assign io_ppu.ppu_ack   = r_ack;
   assign io_ppu.busy      = (r_state != S_IDLE);
   assign o_chr_addr       = r_chr_addr;
   assign o_chr_wdata      = r_chr_wdata;
   assign o_chr_rd         = r_chr_rd;
   assign o_chr_wr         = r_chr_wr;
   assign o_overrun        = r_overrun;
   assign o_chr_timeout    = r_chr_timeout;

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ppu_vram_ctrl
// Directed bench for ppu_vram_ctrl. A behavioural model (palette/nametable
// arrays plus expected completion cycles) predicts ack, busy, rdata, CHR
// strobes and sticky flags; a negedge process compares them every cycle.
// Literal checks after each directed step pin the model to known values.
// ---------------------------------------------------------------------------
module tb_ppu_vram_ctrl;
   localparam int T = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        mirror_v;
   logic [12:0] chr_addr;
   logic [7:0]  chr_wdata;
   logic        chr_rd;
   logic        chr_wr;
   logic [7:0]  chr_rdata;
   logic        chr_ack;
   logic        overrun;
   logic        chr_timeout;

   always #20 clk = ~clk;

   ppu_vram_ctrl_if bus ();

   ppu_vram_ctrl #(.CHR_TIMEOUT(T), .NT_DEPTH(2048)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .io_ppu        (bus),
      .i_mirror_v    (mirror_v),
      .o_chr_addr    (chr_addr),
      .o_chr_wdata   (chr_wdata),
      .o_chr_rd      (chr_rd),
      .o_chr_wr      (chr_wr),
      .i_chr_rdata   (chr_rdata),
      .i_chr_ack     (chr_ack),
      .o_overrun     (overrun),
      .o_chr_timeout (chr_timeout)
   );

   int vec  = 0;
   int miss = 0;
   int cyc  = 0;
   bit chk_en = 0;

   // model state
   logic [5:0]  m_pal [32];
   logic [7:0]  m_nt  [2048];
   int          ack_cyc, busy_from, busy_to, chr_from, chr_to, to_cyc;
   bit          chr_is_wr, exp_overrun, pend_rd;
   logic [7:0]  exp_rdata, pend_rdata, exp_chr_wdata;
   logic [12:0] exp_chr_addr;
   int          chr_rd_cnt;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   function automatic int nt_idx(input int a, input bit mv);
      int tbl;
      tbl = mv ? (a / 1024) % 2 : (a / 2048) % 2;
      return tbl * 1024 + (a % 1024);
   endfunction

   function automatic int pal_idx(input int a);
      int p;
      p = a % 32;
      if (p % 4 == 0) p = p % 16;
      return p;
   endfunction

   function automatic logic [7:0] cur_rdata();
      if (pend_rd && ack_cyc >= 0 && cyc >= ack_cyc) return pend_rdata;
      return exp_rdata;
   endfunction

   task automatic model_reset();
      ack_cyc = -1; busy_from = -1; busy_to = -1;
      chr_from = -1; chr_to = -1; to_cyc = -1;
      exp_overrun = 0; exp_rdata = 8'h00; pend_rd = 0; pend_rdata = 8'h00;
      for (int i = 0; i < 32; i++) m_pal[i] = 6'h00;
   endtask

   task automatic commit();
      if (pend_rd && ack_cyc >= 0) exp_rdata = pend_rdata;
      pend_rd = 0;
   endtask

   // One PPU access. ack_after>0: CHR ack sampled on the ack_after-th edge
   // after accept; 0 means never. inject/abort are cycle offsets (0 = none).
   task automatic issue(input logic [13:0] a, input logic [7:0] wd, input bit rd, input bit wr,
                        input bit mv, input int ack_after, input logic [7:0] crd,
                        input int inject, input int abort);
      int n, lat, m, idx;
      bit is_chr, is_pal, injected;
      commit();
      bus.ppu_addr = a; bus.ppu_wdata = wd;
      bus.ppu_rd_req = rd; bus.ppu_wr_req = wr; mirror_v = mv;
      tick();
      n = cyc; m = 0;
      bus.ppu_rd_req = 0; bus.ppu_wr_req = 0;
      is_chr = (a < 14'h2000);
      is_pal = (a >= 14'h3F00);
      pend_rd = !wr;
      if (is_pal) begin
         idx = pal_idx(int'(a));
         if (wr) m_pal[idx] = wd[5:0]; else pend_rdata = {2'b00, m_pal[idx]};
         lat = 1;
      end else if (!is_chr) begin
         idx = nt_idx(int'(a), mv);
         if (wr) m_nt[idx] = wd; else pend_rdata = m_nt[idx];
         lat = wr ? 1 : 2;
      end else begin
         chr_from = n; chr_is_wr = wr;
         exp_chr_addr = a[12:0]; exp_chr_wdata = wd;
         if (ack_after > 0) begin
            m = n + ack_after; chr_to = m; lat = ack_after + 1; pend_rdata = crd;
         end else begin
            chr_to = n + T + 1; lat = T + 2; pend_rdata = 8'h00;
            if (to_cyc < 0) to_cyc = n + T + 1;
         end
      end
      ack_cyc = n + lat; busy_from = n; busy_to = n + lat;
      while (cyc < n + lat) begin
         if (abort > 0 && cyc == n + abort) begin
            rst = 1;
            tick();
            rst = 0;
            model_reset();
            return;
         end
         injected = 0;
         if (is_chr && ack_after > 0 && cyc == m - 1) begin
            chr_ack = 1; chr_rdata = crd;
         end
         if (inject > 0 && cyc == n + inject) begin
            bus.ppu_rd_req = 1; bus.ppu_addr = 14'h3F00; injected = 1;
         end
         tick();
         if (injected) exp_overrun = 1;
         chr_ack = 0; bus.ppu_rd_req = 0; bus.ppu_addr = a;
      end
   endtask

   // per-cycle compare against the model
   bit in_chr;
   always @(negedge clk) begin
      if (chk_en) begin
         in_chr = (chr_from >= 0) && (cyc >= chr_from) && (cyc < chr_to);
         check("ack",   16'(bus.ppu_ack), 16'(cyc == ack_cyc));
         check("busy",  16'(bus.busy), 16'(busy_from >= 0 && cyc >= busy_from && cyc < busy_to));
         check("rdata", 16'(bus.ppu_rdata), 16'(cur_rdata()));
         check("chr_rd", 16'(chr_rd), 16'(in_chr && !chr_is_wr));
         check("chr_wr", 16'(chr_wr), 16'(in_chr && chr_is_wr));
         check("overrun", 16'(overrun), 16'(exp_overrun));
         check("chr_timeout", 16'(chr_timeout), 16'(to_cyc >= 0 && cyc >= to_cyc));
         if (in_chr) begin
            check("chr_addr", 16'(chr_addr), 16'(exp_chr_addr));
            if (chr_is_wr) check("chr_wdata", 16'(chr_wdata), 16'(exp_chr_wdata));
         end
         if (chr_rd === 1'b1) chr_rd_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec);
      $fatal(1);
   end

   initial begin
      rst = 1; mirror_v = 0; chr_rdata = 8'h00; chr_ack = 0;
      bus.ppu_addr = '0; bus.ppu_wdata = '0; bus.ppu_rd_req = 0; bus.ppu_wr_req = 0;
      for (int i = 0; i < 2048; i++) m_nt[i] = 8'hxx;
      chr_rd_cnt = 0;
      tick();
      model_reset();
      chk_en = 1;
      tick();
      rst = 0;
      check("rst_rdata", 16'(bus.ppu_rdata), 16'h00);
      check("rst_busy",  16'(bus.busy), 16'h0);
      check("rst_chr",   16'({chr_rd, chr_wr}), 16'h0);

      // palette
      issue(14'h3F00, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);
      check("pal_rd_3f00_ack", 16'(bus.ppu_ack), 16'h1);
      check("pal_rd_3f00", 16'(bus.ppu_rdata), 16'h00);
      issue(14'h3F10, 8'hFF, 0, 1, 1, 0, 8'h00, 0, 0);
      issue(14'h3F00, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);
      check("pal_alias_3f10", 16'(bus.ppu_rdata), 16'h3F);
      issue(14'h3F11, 8'h21, 0, 1, 1, 0, 8'h00, 0, 0);
      issue(14'h3F01, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);
      check("pal_no_alias_3f01", 16'(bus.ppu_rdata), 16'h00);
      issue(14'h3F0C, 8'h2A, 0, 1, 1, 0, 8'h00, 0, 0);
      issue(14'h3F1C, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);
      check("pal_alias_3f1c", 16'(bus.ppu_rdata), 16'h2A);

      // nametable mirroring
      issue(14'h2005, 8'hAB, 0, 1, 1, 0, 8'h00, 0, 0);
      issue(14'h2805, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);
      check("nt_vmirror_ack", 16'(bus.ppu_ack), 16'h1);
      check("nt_vmirror", 16'(bus.ppu_rdata), 16'hAB);
      issue(14'h2005, 8'hCD, 0, 1, 0, 0, 8'h00, 0, 0);
      issue(14'h2405, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0);
      check("nt_hmirror", 16'(bus.ppu_rdata), 16'hCD);
      issue(14'h3005, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0);
      check("nt_3005_alias", 16'(bus.ppu_rdata), 16'hCD);
      issue(14'h2FFF, 8'h9E, 0, 1, 1, 0, 8'h00, 0, 0);
      issue(14'h27FF, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);
      check("nt_vmirror_hi", 16'(bus.ppu_rdata), 16'h9E);

      // CHR read acked after three strobe cycles
      chr_rd_cnt = 0;
      issue(14'h0123, 8'h00, 1, 0, 1, 3, 8'h5A, 0, 0);
      check("chr_rd_cycles", 16'(chr_rd_cnt), 16'd3);
      check("chr_rd_data", 16'(bus.ppu_rdata), 16'h5A);

      // CHR ack on the timeout cycle is a normal completion
      issue(14'h1F00, 8'h00, 1, 0, 1, T + 1, 8'hC3, 0, 0);
      check("chr_ack_at_tmo_data", 16'(bus.ppu_rdata), 16'hC3);
      check("chr_ack_at_tmo_flag", 16'(chr_timeout), 16'h0);

      // CHR write, never acked
      issue(14'h1ABC, 8'h77, 0, 1, 1, 0, 8'h00, 0, 0);
      check("tmo_ack", 16'(bus.ppu_ack), 16'h1);
      check("tmo_flag", 16'(chr_timeout), 16'h1);
      check("tmo_wr_low", 16'(chr_wr), 16'h0);
      check("tmo_rdata_held", 16'(bus.ppu_rdata), 16'hC3);

      // request during CHR wait
      issue(14'h0040, 8'h00, 1, 0, 1, 5, 8'h3C, 2, 0);
      check("overrun_flag", 16'(overrun), 16'h1);
      check("overrun_rdata", 16'(bus.ppu_rdata), 16'h3C);

      // rd+wr together: write wins
      issue(14'h3F02, 8'h15, 1, 1, 1, 0, 8'h00, 0, 0);
      check("rdwr_rdata_held", 16'(bus.ppu_rdata), 16'h3C);
      issue(14'h3F02, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);
      check("rdwr_readback", 16'(bus.ppu_rdata), 16'h15);

      // reset during CHR wait
      issue(14'h0200, 8'h00, 1, 0, 1, 0, 8'h00, 0, 4);
      check("abort_chr_rd", 16'(chr_rd), 16'h0);
      check("abort_busy", 16'(bus.busy), 16'h0);
      check("abort_ack", 16'(bus.ppu_ack), 16'h0);
      tick();
      issue(14'h3F02, 8'h00, 1, 0, 1, 0, 8'h00, 0, 0);
      check("pal_cleared", 16'(bus.ppu_rdata), 16'h00);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/ppu_vram_ctrl.md
Name: ppu_vram_ctrl

Overview:
PPU-side memory controller sitting directly downstream of ppu_top's memory port (addr/data_out/write_request/read_request/data_in).
Decodes the 14-bit PPU address space and serves three targets:
- external CHR space (pattern tables) via a req/ack handshake
- internal 2 KB nametable RAM (CIRAM) with selectable mirroring
- internal 32-entry palette RAM with NES palette mirroring

Returns read data with a one-cycle ack pulse, and flags overruns and CHR timeouts.

Parameters:
CHR_TIMEOUT, 15, cycles to wait for chr_ack before forcing completion (4-bit counter, 1..15)
NT_DEPTH, 2048, CIRAM bytes (11-bit address)

Ports:
clk  in  1  system clock (25 MHz)
rst  in  1  synchronous active-high reset
ppu_addr  in  14  PPU address (from ppu_top addr)
ppu_wdata  in  8  write data (from ppu_top data_out)
ppu_rd_req  in  1  single-cycle read request (ppu_top read_request)
ppu_wr_req  in  1  single-cycle write request (ppu_top write_request)
ppu_rdata  out  8  read data (to ppu_top data_in); valid when ppu_ack=1, held until next read completes
ppu_ack  out  1  one-cycle completion pulse for reads and writes
busy  out  1  high while a request is in progress
mirror_v  in  1  1=vertical mirroring, 0=horizontal; sampled at request accept
chr_addr  out  13  CHR address
chr_wdata  out  8  CHR write data
chr_rd  out  1  CHR read strobe, held until chr_ack
chr_wr  out  1  CHR write strobe, held until chr_ack
chr_rdata  in  8  CHR read data, valid with chr_ack
chr_ack  in  1  CHR completion
overrun  out  1  sticky: a request arrived while busy
chr_timeout  out  1  sticky: CHR access hit CHR_TIMEOUT

Behaviour:

Reset:
- All outputs go to 0: ppu_rdata=0x00, ppu_ack, busy, chr_*, overrun, chr_timeout.
- Palette RAM is cleared to 0. CIRAM is not cleared.
- Reset mid-operation aborts the access: no ack is issued, and chr_rd/chr_wr drop the cycle after rst is sampled.

Request accept:
- Requests are accepted only in IDLE. At the accepting edge, latch addr, wdata, op and mirror_v.
- rd and wr both high: the write executes and the read is dropped.
- Any request while not IDLE is ignored and sets overrun.
- A request in the same cycle as ppu_ack is accepted, since the FSM is already back in IDLE.

Address decode (on the latched address a):
- a[13]=0 -> CHR, chr_addr=a[12:0].
- a[13:8]=6'h3F -> palette, index p=a[4:0]; if p[1:0]=0 then p[4] is forced to 0, so 3F10/14/18/1C alias 3F00/04/08/0C.
- Else -> nametable (2000-3EFF; bit 12 ignored, so 3000-3EFF mirrors 2000-2EFF).
  - mirror_v=1: CIRAM address = {a[10], a[9:0]}.
  - mirror_v=0: CIRAM address = {a[11], a[9:0]}.

Palette:
- Entries are 6 bits wide. Writes store wdata[5:0].
- Reads return {2'b00, entry}.

FSM states: IDLE, PAL, NT_RD, CHR, DONE.
- IDLE -> PAL for any palette access.
- IDLE -> NT_RD for nametable reads.
- IDLE -> DONE for nametable writes (the write is performed at accept+1).
- IDLE -> CHR for CHR accesses.
- PAL: perform the access; ack; -> IDLE.
- NT_RD: synchronous RAM read (1 cycle) -> DONE.
- CHR: drive chr_rd or chr_wr, chr_addr and chr_wdata.
  - On chr_ack: capture chr_rdata; -> DONE.
  - When the wait counter reaches CHR_TIMEOUT with no chr_ack: set chr_timeout, rdata=0x00, -> DONE.
  - chr_ack arriving on the same cycle as the timeout counts as a normal ack.
- DONE: ppu_ack=1; -> IDLE.

Latency (request sampled at edge N):
- Palette read or write: ack at N+1.
- Nametable write: ack at N+1.
- Nametable read: ack at N+2.
- CHR: strobe from N+1; ack one cycle after chr_ack; ack no later than N+CHR_TIMEOUT+2.

Other rules:
- busy = (state != IDLE).
- ppu_rdata updates only on read completions; writes leave it unchanged.
- Sticky flags clear only on rst.
- Counter width is 4 bits; a CHR_TIMEOUT above 15 is not supported.

Test Plan:
- Reset, then read palette 3F00 -> ppu_rdata=0x00, ack at N+1; write 0xFF to 3F10, read 3F00 -> 0x3F; write 0x21 to 3F11, read 3F01 -> unchanged 0x00.
- mirror_v=1: write 0xAB to 2005, read 2805 -> 0xAB, ack at N+2. mirror_v=0: write 0xCD to 2005, read 2405 -> 0xCD. Read 3005 -> same as 2005.
- CHR read 0x0123 with chr_ack after 3 cycles and chr_rdata=0x5A -> chr_rd high for exactly 3 cycles with chr_addr=0x0123; ppu_rdata=0x5A with ack one cycle after chr_ack.
- CHR write with chr_ack never asserted -> chr_timeout=1, ack at N+17, chr_wr deasserted, ppu_rdata unchanged.
- Request during CHR wait -> overrun=1, no extra ack. rd+wr together to 3F02 with 0x15 -> write occurs, one ack; a following read returns 0x15.
- Assert rst during CHR wait -> chr_rd=0 next cycle, no ack, busy=0, palette cleared.
